message_packer: RTL and testbench

MESSAGE_PACKER -- requirements
Module: message_packer

---
 rtl/message_packer.sv | 155 +++++++++++++++
 tb/tb_message_packer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/message_packer.sv
// message_packer: captures one trade message (eight fields) in a single
// handshake and emits it as three 32-bit words on a valid/ready stream.
//
//   word 1 = {stockSymbol, tradeFunction, quantity, currentPrice, 9'b0}
//   word 2 = {dateStamp, timeStamp}
//   word 3 = {buyPrice, sellPrice, 12'b0}
//            or, with PACKER_CHECKSUM_EN defined:
//            {buyPrice, sellPrice, 4'b0, xor of the eight bytes of words 1 and 2}
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_ready message-field handshake (ready only while idle)
//   stockSymbol .. sellPrice  message fields, sampled on an accepted in_valid
//   out_word          word being offered (zero while idle)
//   out_valid/out_ready word handshake
//   out_first/out_last flag word 1 / word 3
//   msg_count         number of fully transmitted messages (wraps at 16 bits)
//
// Optional feature macro: PACKER_CHECKSUM_EN.
// Only regWidth = 32 is supported.

module message_packer #(
    parameter int regWidth = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          stockSymbol,
    input  logic [2:0]          tradeFunction,
    input  logic [7:0]          quantity,
    input  logic [9:0]          currentPrice,
    input  logic [20:0]         dateStamp,
    input  logic [10:0]         timeStamp,
    input  logic [9:0]          buyPrice,
    input  logic [9:0]          sellPrice,
    output logic [regWidth-1:0] out_word,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_first,
    output logic                out_last,
    output logic [15:0]         msg_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] W1   = 2'd1;
    localparam logic [1:0] W2   = 2'd2;
    localparam logic [1:0] W3   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] msg_count_q, msg_count_d;

    // Holding registers for the captured message
    logic [1:0]  symbol_q;
    logic [2:0]  func_q;
    logic [7:0]  qty_q;
    logic [9:0]  price_q;
    logic [20:0] date_q;
    logic [10:0] time_q;
    logic [9:0]  buy_q;
    logic [9:0]  sell_q;

    logic        accept;
    logic [31:0] word1, word2, word3;

    assign accept = (state_q == IDLE) && in_valid;

    assign word1 = {symbol_q, func_q, qty_q, price_q, 9'd0};
    assign word2 = {date_q, time_q};

`ifdef PACKER_CHECKSUM_EN
    logic [7:0] checksum;
    assign checksum = word1[31:24] ^ word1[23:16] ^ word1[15:8] ^ word1[7:0]
                    ^ word2[31:24] ^ word2[23:16] ^ word2[15:8] ^ word2[7:0];
    assign word3 = {buy_q, sell_q, 4'd0, checksum};
`else
    assign word3 = {buy_q, sell_q, 12'd0};
`endif

    // Next state: each word state advances only on a transfer
    always_comb begin
        state_d     = state_q;
        msg_count_d = msg_count_q;
        case (state_q)
            IDLE: if (in_valid) state_d = W1;
            W1:   if (out_ready) state_d = W2;
            W2:   if (out_ready) state_d = W3;
            W3: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    msg_count_d = msg_count_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            msg_count_q <= 16'd0;
            symbol_q    <= '0;
            func_q      <= '0;
            qty_q       <= '0;
            price_q     <= '0;
            date_q      <= '0;
            time_q      <= '0;
            buy_q       <= '0;
            sell_q      <= '0;
        end else begin
            state_q     <= state_d;
            msg_count_q <= msg_count_d;
            if (accept) begin
                symbol_q <= stockSymbol;
                func_q   <= tradeFunction;
                qty_q    <= quantity;
                price_q  <= currentPrice;
                date_q   <= dateStamp;
                time_q   <= timeStamp;
                buy_q    <= buyPrice;
                sell_q   <= sellPrice;
            end
        end
    end

    // Outputs decode purely from state, so they stay stable under backpressure
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_first = 1'b0;
        out_last  = 1'b0;
        out_word  = '0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            W1: begin
                out_valid = 1'b1;
                out_first = 1'b1;
                out_word  = word1;
            end
            W2: begin
                out_valid = 1'b1;
                out_word  = word2;
            end
            W3: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_word  = word3;
            end
            default: in_ready = 1'b0;
        endcase
    end

    assign msg_count = msg_count_q;

endmodule

// File: tb/tb_message_packer.sv
// Self-checking bench for message_packer. Expected words come from a
// field-level packing model; inputs change on the falling edge and outputs
// are sampled there too.

module tb_message_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  stockSymbol;
    logic [2:0]  tradeFunction;
    logic [7:0]  quantity;
    logic [9:0]  currentPrice;
    logic [20:0] dateStamp;
    logic [10:0] timeStamp;
    logic [9:0]  buyPrice;
    logic [9:0]  sellPrice;
    logic [31:0] out_word;
    logic        out_valid;
    logic        out_ready;
    logic        out_first;
    logic        out_last;
    logic [15:0] msg_count;

    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;
    logic [15:0] exp_count = 16'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    message_packer #(.regWidth(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .stockSymbol(stockSymbol), .tradeFunction(tradeFunction), .quantity(quantity),
        .currentPrice(currentPrice), .dateStamp(dateStamp), .timeStamp(timeStamp),
        .buyPrice(buyPrice), .sellPrice(sellPrice), .out_word(out_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_first(out_first),
        .out_last(out_last), .msg_count(msg_count)
    );

    typedef struct packed {
        logic [1:0]  sym;
        logic [2:0]  func;
        logic [7:0]  qty;
        logic [9:0]  price;
        logic [20:0] date;
        logic [10:0] tstamp;
        logic [9:0]  buy;
        logic [9:0]  sell;
    } msg_t;

`ifdef PACKER_CHECKSUM_EN
    localparam logic [31:0] BasicWord3 = 32'h190C8074;
`else
    localparam logic [31:0] BasicWord3 = 32'h190C8000;
`endif

    // Field-level packing model: word idx = 1, 2 or 3
    function automatic logic [31:0] exp_word(input msg_t m, input int idx);
        logic [31:0] w1, w2, w3;
        w1 = (32'(m.sym) << 30) | (32'(m.func) << 27) | (32'(m.qty) << 19)
           | (32'(m.price) << 9);
        w2 = (32'(m.date) << 11) | 32'(m.tstamp);
        w3 = (32'(m.buy) << 22) | (32'(m.sell) << 12);
`ifdef PACKER_CHECKSUM_EN
        begin
            logic [7:0] cs;
            cs = 8'd0;
            for (int b = 0; b < 4; b++) cs = cs ^ 8'(w1 >> (8 * b)) ^ 8'(w2 >> (8 * b));
            w3 = w3 | 32'(cs);
        end
`endif
        case (idx)
            1:       return w1;
            2:       return w2;
            default: return w3;
        endcase
    endfunction

    function automatic msg_t rand_msg();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[74:0];
    endfunction

    function automatic msg_t basic_msg();
        msg_t m;
        m.sym = 2'd2; m.func = 3'd3; m.qty = 8'h2A; m.price = 10'h155;
        m.date = 21'h0A1B2C; m.tstamp = 11'h3FF; m.buy = 10'h064; m.sell = 10'h0C8;
        return m;
    endfunction

    task automatic drive(input msg_t m);
        stockSymbol = m.sym; tradeFunction = m.func; quantity = m.qty;
        currentPrice = m.price; dateStamp = m.date; timeStamp = m.tstamp;
        buyPrice = m.buy; sellPrice = m.sell;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive('0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_count = 16'd0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
        checks++; if ({out_first, out_last} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {out_first, out_last}); end
        checks++; if (out_word !== 32'd0) begin failures++; $display("FAIL reset_out_word got=%h exp=0", out_word); end
        checks++; if (msg_count !== 16'd0) begin failures++; $display("FAIL reset_msg_count got=%h exp=0", msg_count); end
    endtask

    task automatic test_basic();
        drive(basic_msg()); in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        checks++; if ({out_valid, out_first, out_last, in_ready} !== 4'b1100) begin failures++; $display("FAIL basic_w1_flags got=%b exp=1100", {out_valid, out_first, out_last, in_ready}); end
        checks++; if (out_word !== 32'h9952AA00) begin failures++; $display("FAIL basic_w1 got=%h exp=9952aa00", out_word); end
        @(negedge clk);
        checks++; if ({out_valid, out_first, out_last} !== 3'b100) begin failures++; $display("FAIL basic_w2_flags got=%b exp=100", {out_valid, out_first, out_last}); end
        checks++; if (out_word !== 32'h50D963FF) begin failures++; $display("FAIL basic_w2 got=%h exp=50d963ff", out_word); end
        @(negedge clk);
        checks++; if ({out_valid, out_first, out_last} !== 3'b101) begin failures++; $display("FAIL basic_w3_flags got=%b exp=101", {out_valid, out_first, out_last}); end
        checks++; if (out_word !== BasicWord3) begin failures++; $display("FAIL basic_w3 got=%h exp=%h", out_word, BasicWord3); end
        @(negedge clk);
        exp_count = exp_count + 16'd1;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL basic_idle got=%b exp=01", {out_valid, in_ready}); end
        checks++; if (out_word !== 32'd0) begin failures++; $display("FAIL basic_idle_word got=%h exp=0", out_word); end
        checks++; if (msg_count !== 16'd1) begin failures++; $display("FAIL basic_count got=%h exp=1", msg_count); end
    endtask

    task automatic test_backpressure();
        msg_t m;
        m = basic_msg();
        drive(m); in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        checks++; if (out_word !== exp_word(m, 1)) begin failures++; $display("FAIL bp_w1 got=%h exp=%h", out_word, exp_word(m, 1)); end
        @(negedge clk); out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({out_valid, out_first, out_last} !== 3'b100 || out_word !== exp_word(m, 2)) begin failures++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=100/%h", i, {out_valid, out_first, out_last}, out_word, exp_word(m, 2)); end
            @(negedge clk);
        end
        checks++; if (out_word !== exp_word(m, 2)) begin failures++; $display("FAIL bp_still_w2 got=%h exp=%h", out_word, exp_word(m, 2)); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_last !== 1'b1 || out_word !== exp_word(m, 3)) begin failures++; $display("FAIL bp_w3 got=%b/%h exp=1/%h", out_last, out_word, exp_word(m, 3)); end
        @(negedge clk);
        exp_count = exp_count + 16'd1;
        checks++; if (msg_count !== exp_count) begin failures++; $display("FAIL bp_count got=%h exp=%h", msg_count, exp_count); end
    endtask

    task automatic test_stall();
        msg_t m1, m2;
        m1 = rand_msg(); m2 = rand_msg();
        drive(m1); in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            drive(rand_msg());
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready word=%0d got=%0h exp=0", k, in_ready); end
            checks++; if (out_word !== exp_word(m1, k)) begin failures++; $display("FAIL stall_word word=%0d got=%h exp=%h", k, out_word, exp_word(m1, k)); end
        end
        @(negedge clk);
        exp_count = exp_count + 16'd1;
        checks++; if (in_ready !== 1'b1 || msg_count !== exp_count) begin failures++; $display("FAIL stall_idle got=%0h/%h exp=1/%h", in_ready, msg_count, exp_count); end
        drive(m2);
        @(negedge clk); in_valid = 1'b0;
        checks++; if (out_word !== exp_word(m2, 1)) begin failures++; $display("FAIL stall_next_w1 got=%h exp=%h", out_word, exp_word(m2, 1)); end
        repeat (3) @(negedge clk);
        exp_count = exp_count + 16'd1;
        checks++; if (msg_count !== exp_count) begin failures++; $display("FAIL stall_count got=%h exp=%h", msg_count, exp_count); end
    endtask

    task automatic test_reset_midflight();
        drive(rand_msg()); in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_first !== 1'b0) begin failures++; $display("FAIL rstmid_in_w2 got=%b exp=10", {out_valid, out_first}); end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        exp_count = 16'd0;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL rstmid_state got=%b exp=01", {out_valid, in_ready}); end
        checks++; if (msg_count !== 16'd0) begin failures++; $display("FAIL rstmid_count got=%h exp=0", msg_count); end
        // Reset must win over a simultaneous accept
        drive(rand_msg()); in_valid = 1'b1; rst = 1'b1;
        @(negedge clk); rst = 1'b0; in_valid = 1'b0;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL rst_priority got=%b exp=01", {out_valid, in_ready}); end
    endtask

    task automatic test_random();
        msg_t m;
        int   idx, budget;
        for (int n = 0; n < 30; n++) begin
            m = rand_msg();
            drive(m); in_valid = 1'b1;
            @(negedge clk);
            idx = 1; budget = 0;
            while (idx <= 3 && budget < 100) begin
                out_ready = ($urandom_range(0, 2) != 0);
                in_valid = 1'(($urandom));
                drive(rand_msg());
                checks++; if ({out_valid, out_first, out_last} !== {1'b1, idx == 1, idx == 3} || out_word !== exp_word(m, idx)) begin failures++; $display("FAIL rand_word msg=%0d word=%0d got=%b/%h exp=%h", n, idx, {out_valid, out_first, out_last}, out_word, exp_word(m, idx)); end
                if (out_ready) idx++;
                @(negedge clk);
                budget++;
            end
            in_valid = 1'b0;
            if (idx <= 3) begin failures++; $display("FAIL rand_timeout msg=%0d word=%0d", n, idx); end
            exp_count = exp_count + 16'd1;
            checks++; if (in_ready !== 1'b1 || msg_count !== exp_count) begin failures++; $display("FAIL rand_count msg=%0d got=%0h/%h exp=1/%h", n, in_ready, msg_count, exp_count); end
        end
    endtask

    task automatic test_back_to_back_wrap();
        msg_t q[$];
        msg_t m;
        int   sent, done, last_first;
        logic pend;
        in_valid = 1'b0; out_ready = 1'b1;
        // Preload the counter near its limit instead of running 65k messages
        force dut.msg_count_q = 16'hFFFD;
        @(negedge clk);
        release dut.msg_count_q;
        exp_count = 16'hFFFD;
        checks++; if (msg_count !== exp_count) begin failures++; $display("FAIL wrap_preload got=%h exp=%h", msg_count, exp_count); end
        sent = 0; done = 0; last_first = -1; pend = 1'b0;
        for (int c = 0; c < 60 && done < 6; c++) begin
            if (pend) begin
                pend = 1'b0; done++;
                exp_count = exp_count + 16'd1;
                checks++; if (msg_count !== exp_count) begin failures++; $display("FAIL wrap_count msg=%0d got=%h exp=%h", done, msg_count, exp_count); end
            end
            if (out_first) begin
                if (last_first >= 0) begin
                    checks++; if (cycle - last_first !== 4) begin failures++; $display("FAIL wrap_spacing got=%0d exp=4", cycle - last_first); end
                end
                last_first = cycle;
                checks++; if (q.size() == 0 || out_word !== exp_word(q[0], 1)) begin failures++; $display("FAIL wrap_w1 got=%h", out_word); end
            end
            if (out_last) begin
                pend = 1'b1;
                checks++; if (q.size() == 0 || out_word !== exp_word(q[0], 3)) begin failures++; $display("FAIL wrap_w3 got=%h", out_word); end
                if (q.size() != 0) void'(q.pop_front());
            end
            if (in_ready && sent < 6) begin
                m = rand_msg(); drive(m); q.push_back(m); in_valid = 1'b1; sent++;
            end else if (in_ready) begin
                in_valid = 1'b0;
            end else begin
                drive(rand_msg());
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (done < 6) begin failures++; $display("FAIL wrap_timeout done=%0d exp=6", done); end
        checks++; if (msg_count !== 16'h0003) begin failures++; $display("FAIL wrap_final got=%h exp=0003", msg_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_stall();
        test_reset_midflight();
        test_random();
        test_back_to_back_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
